awg_cmd_parser: RTL

AWG_CMD_PARSER -- requirements
Module: awg_cmd_parser

---
 rtl/awg_cmd_parser.sv | 104 ++++++++++
 1 files changed

// File: rtl/awg_cmd_parser.sv
// awg_cmd_parser: UART byte-stream frame parser driving AWG configuration registers.
// Define AWG_CMD_CHECKSUM_EN to require a trailing CHK = CMD ^ D_HI ^ D_LO byte.
module awg_cmd_parser #(
    parameter int          TIMEOUT_CYCLES = 100000,
    parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  uart_data,
    input  logic        data_valid,
    output logic [1:0]  waveform_type,
    output logic [15:0] frequency,
    output logic [9:0]  amplitude,
    output logic [9:0]  dc_offset,
    output logic        cfg_update,
    output logic        frame_err,
    output logic        busy
);
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, GOT_SYNC, GOT_CMD, GOT_DHI, GOT_DLO} state_t;

    state_t         r_state, w_next;
    logic [7:0]     r_cmd, r_dhi;
    logic [CW-1:0]  r_tcnt;
    logic [1:0]     r_wt;
    logic [15:0]    r_freq;
    logic [9:0]     r_amp, r_dc;
    logic           r_cfg_update, r_frame_err;
    logic [15:0]    w_d;
    logic           w_last, w_chk_ok, w_ok, w_final, w_timeout;

`ifdef AWG_CMD_CHECKSUM_EN
    logic [7:0] r_dlo;
    assign w_d      = {r_dhi, r_dlo};
    assign w_last   = r_state == GOT_DLO;
    assign w_chk_ok = uart_data == (r_cmd ^ r_dhi ^ r_dlo);
`else
    assign w_d      = {r_dhi, uart_data};
    assign w_last   = r_state == GOT_DHI;
    assign w_chk_ok = 1'b1;
`endif

    assign busy          = r_state != IDLE;
    assign waveform_type = r_wt;
    assign frequency     = r_freq;
    assign amplitude     = r_amp;
    assign dc_offset     = r_dc;
    assign cfg_update    = r_cfg_update;
    assign frame_err     = r_frame_err;

    // A byte arriving on the timeout cycle suppresses the timeout.
    always_comb begin
        w_timeout = busy && !data_valid && r_tcnt == CW'(TIMEOUT_CYCLES - 1);
        w_final   = data_valid && w_last;
        w_ok      = w_chk_ok && ((r_cmd == 8'h01 && w_d[15:2] == 14'd0) || r_cmd == 8'h02 ||
                    ((r_cmd == 8'h03 || r_cmd == 8'h04) && w_d[15:10] == 6'd0));
        w_next    = r_state;
        if (data_valid)
            w_next = (w_last || (r_state == IDLE && uart_data != SYNC_BYTE)) ? IDLE : state_t'(r_state + 3'd1);
        else if (w_timeout)
            w_next = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_tcnt  <= '0;
        end else begin
            r_state <= w_next;
            r_tcnt  <= (data_valid || !busy || w_timeout) ? '0 : r_tcnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd        <= '0;
            r_dhi        <= '0;
`ifdef AWG_CMD_CHECKSUM_EN
            r_dlo        <= '0;
`endif
            r_wt         <= 2'd0;
            r_freq       <= 16'h0100;
            r_amp        <= 10'h1FF;
            r_dc         <= 10'h200;
            r_cfg_update <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (data_valid && r_state == GOT_SYNC) r_cmd <= uart_data;
            if (data_valid && r_state == GOT_CMD)  r_dhi <= uart_data;
`ifdef AWG_CMD_CHECKSUM_EN
            if (data_valid && r_state == GOT_DHI)  r_dlo <= uart_data;
`endif
            r_cfg_update <= w_final && w_ok;
            r_frame_err  <= (w_final && !w_ok) || w_timeout;
            if (w_final && w_ok) begin
                if (r_cmd == 8'h01) r_wt   <= w_d[1:0];
                if (r_cmd == 8'h02) r_freq <= w_d;
                if (r_cmd == 8'h03) r_amp  <= w_d[9:0];
                if (r_cmd == 8'h04) r_dc   <= w_d[9:0];
            end
        end
    end
endmodule
